gesture_uart_rx: RTL and testbench

Receives gesture commands from the host (vision/ML PC) over a 3.3 V UART line and presents a validated, held 8-bit gesture code to gesture_decoder. It contains an 8N1 UART byte receiver, a 3-byte frame parser with checksum, and a link watchdog. Output gesture is a level, held until the next valid frame or a watchdog timeout. Code 0x00 means "hold current servo positions".

---
 rtl/gesture_link_pkg.sv | 8 +
 rtl/uart_rx_byte.sv | 91 +++++++++
 rtl/gesture_uart_rx.sv | 100 ++++++++++
 tb/tb_gesture_uart_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/gesture_link_pkg.sv
// Shared constants and state encodings for the host gesture UART link.
package gesture_link_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CHK_KEY   = 8'h5A;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_SYNC, P_CODE, P_CHK} parse_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with 2-FF input synchronizer.
//   state    | meaning
//   RX_IDLE  | waiting for falling edge on synced rx
//   RX_START | counting to mid start bit, rejects glitches
//   RX_DATA  | sampling 8 data bits LSB first
//   RX_STOP  | sampling stop bit, flags byte or framing error
module uart_rx_byte
  import gesture_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       byte_ferr
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state;
  logic             rx_meta;
  logic             rx_sync;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      data       <= '0;
      byte_valid <= 1'b0;
      byte_ferr  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      byte_valid <= 1'b0;
      byte_ferr  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rx_sync) begin
            state   <= RX_START;
            cnt     <= HALF_LOAD;
            bit_cnt <= '0;
          end
        end
        RX_START: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (rx_sync) begin
            state <= RX_IDLE;
          end else begin
            state <= RX_DATA;
            cnt   <= BIT_LOAD;
          end
        end
        RX_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            shreg   <= {rx_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            cnt     <= BIT_LOAD;
            if (bit_cnt == 3'd7) state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= RX_IDLE;
            if (rx_sync) begin
              data       <= shreg;
              byte_valid <= 1'b1;
            end else begin
              byte_ferr <= 1'b1;
            end
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/gesture_uart_rx.sv
// Gesture command receiver: frame parser, byte-gap timer, link watchdog, held output.
//   state  | meaning
//   P_SYNC | hunting for sync byte, other bytes dropped
//   P_CODE | next byte is the gesture code
//   P_CHK  | next byte is checksum (code ^ key)
module gesture_uart_rx
  import gesture_link_pkg::*;
#(
  parameter int CLKS_PER_BIT        = 434,
  parameter int BYTE_GAP_CYCLES     = 50000,
  parameter int LINK_TIMEOUT_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] gesture,
  output logic       gesture_valid,
  output logic       frame_err,
  output logic       link_up
);
  localparam int GAP_W = $clog2(BYTE_GAP_CYCLES);
  localparam int WD_W  = $clog2(LINK_TIMEOUT_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(BYTE_GAP_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(LINK_TIMEOUT_CYCLES - 1);

  logic [7:0]       data;
  logic             byte_valid;
  logic             byte_ferr;
  parse_state_t     pstate;
  logic [7:0]       code;
  logic [GAP_W-1:0] gap_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic             match;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .byte_valid (byte_valid),
    .byte_ferr  (byte_ferr)
  );

  assign match = byte_valid && (pstate == P_CHK) && (data == (code ^ CHK_KEY));

  always_ff @(posedge clk) begin
    if (reset) begin
      pstate        <= P_SYNC;
      code          <= '0;
      gap_cnt       <= '0;
      wd_cnt        <= WD_LOAD;
      gesture       <= '0;
      gesture_valid <= 1'b0;
      frame_err     <= 1'b0;
      link_up       <= 1'b0;
    end else begin
      gesture_valid <= 1'b0;
      frame_err     <= 1'b0;

      if (byte_ferr) begin
        frame_err <= 1'b1;
        pstate    <= P_SYNC;
      end else if (byte_valid) begin
        gap_cnt <= GAP_LOAD;
        case (pstate)
          P_SYNC: if (data == SYNC_BYTE) pstate <= P_CODE;
          P_CODE: begin
            code   <= data;
            pstate <= P_CHK;
          end
          P_CHK: begin
            pstate <= P_SYNC;
            if (!match) frame_err <= 1'b1;
          end
          default: pstate <= P_SYNC;
        endcase
      end else if (pstate != P_SYNC) begin
        if (gap_cnt == '0) begin
          frame_err <= 1'b1;
          pstate    <= P_SYNC;
        end else begin
          gap_cnt <= gap_cnt - GAP_W'(1);
        end
      end

      // a match in the expiry cycle takes precedence over the timeout
      if (match) begin
        gesture       <= code;
        gesture_valid <= 1'b1;
        link_up       <= 1'b1;
        wd_cnt        <= WD_LOAD;
      end else if (wd_cnt == '0) begin
        gesture <= '0;
        link_up <= 1'b0;
      end else begin
        wd_cnt <= wd_cnt - WD_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_gesture_uart_rx.sv
// Directed bench for gesture_uart_rx with scaled-down timing parameters.
module tb_gesture_uart_rx;
  localparam int CPB  = 16;
  localparam int GAP  = 400;
  localparam int LINK = 5000;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] gesture;
  logic       gesture_valid;
  logic       frame_err;
  logic       link_up;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int gv_cnt  = 0;
  int fe_cnt  = 0;
  int gv_cyc  = 0;
  int stop_cyc = 0;
  int gv0, fe0;

  gesture_uart_rx #(
    .CLKS_PER_BIT        (CPB),
    .BYTE_GAP_CYCLES     (GAP),
    .LINK_TIMEOUT_CYCLES (LINK)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .gesture       (gesture),
    .gesture_valid (gesture_valid),
    .frame_err     (frame_err),
    .link_up       (link_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (gesture_valid) begin
      gv_cnt = gv_cnt + 1;
      gv_cyc = cyc;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (gesture_valid && frame_err) begin
      errors = errors + 1;
      $error("FAIL excl: gesture_valid=1 and frame_err=1 observed, required not both");
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val = 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    stop_cyc = cyc + 1;
    drive_bit(stop_val);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    gv0 = gv_cnt;
    fe0 = fe_cnt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rx    = 1'b1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_gesture", gesture, 0);
    chk("rst_gv", gesture_valid, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_link", link_up, 0);
    reset = 1'b0;
    idle(20);

    // 1: good frame; 2-FF sync + 8-cycle half bit put the stop sample 10 clk
    // after the stop bit begins, then byte_valid, then the gesture register.
    mark();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h59);
    idle(20);
    chk("t1_gesture", gesture, 8'h03);
    chk("t1_gv_cnt", gv_cnt - gv0, 1);
    chk("t1_link", link_up, 1);
    chk("t1_fe_cnt", fe_cnt - fe0, 0);
    chk("t1_latency", gv_cyc - stop_cyc, 11);

    // 2: bad checksum
    mark();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
    idle(20);
    chk("t2_fe_cnt", fe_cnt - fe0, 1);
    chk("t2_gv_cnt", gv_cnt - gv0, 0);
    chk("t2_gesture", gesture, 8'h03);
    chk("t2_link", link_up, 1);

    // 3: junk before sync, then framing error, then recovery
    mark();
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h5D);
    idle(20);
    chk("t3_junk_fe", fe_cnt - fe0, 0);
    chk("t3_gv_cnt", gv_cnt - gv0, 1);
    chk("t3_gesture", gesture, 8'h07);
    mark();
    send_byte(8'hA5); send_byte(8'h0B, 1'b0);
    idle(20 * CPB);
    chk("t3_ferr_fe", fe_cnt - fe0, 1);
    chk("t3_ferr_gv", gv_cnt - gv0, 0);
    chk("t3_ferr_gesture", gesture, 8'h07);
    mark();
    send_byte(8'hA5); send_byte(8'h0B); send_byte(8'h51);
    idle(20);
    chk("t3_rec_gesture", gesture, 8'h0B);
    chk("t3_rec_gv", gv_cnt - gv0, 1);

    // 4: glitch rejection and byte-gap timeout
    mark();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(60);
    chk("t4_glitch_fe", fe_cnt - fe0, 0);
    chk("t4_glitch_gv", gv_cnt - gv0, 0);
    mark();
    send_byte(8'hA5);
    idle(350);
    chk("t4_gap_early", fe_cnt - fe0, 0);
    idle(100);
    chk("t4_gap_fe", fe_cnt - fe0, 1);
    mark();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h5B);
    idle(20);
    chk("t4_gesture", gesture, 8'h01);
    chk("t4_gv_cnt", gv_cnt - gv0, 1);

    // 5: link watchdog, checked either side of expiry
    mark();
    idle(4900);
    chk("t5_pre_link", link_up, 1);
    chk("t5_pre_gesture", gesture, 8'h01);
    idle(200);
    chk("t5_to_gesture", gesture, 0);
    chk("t5_to_link", link_up, 0);
    chk("t5_to_gv", gv_cnt - gv0, 0);
    mark();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h58);
    idle(20);
    chk("t5_gesture", gesture, 8'h02);
    chk("t5_link", link_up, 1);
    chk("t5_gv_cnt", gv_cnt - gv0, 1);

    // 6: reset in the middle of the code byte (0x04)
    send_byte(8'hA5);
    drive_bit(1'b0);
    drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_gesture", gesture, 0);
    chk("t6_rst_gv", gesture_valid, 0);
    chk("t6_rst_fe", frame_err, 0);
    chk("t6_rst_link", link_up, 0);
    reset = 1'b0;
    mark();
    for (int i = 0; i < 5; i++) drive_bit(1'b0);
    drive_bit(1'b1);
    send_byte(8'h5E);
    idle(30 * CPB);
    chk("t6_tail_gv", gv_cnt - gv0, 0);
    chk("t6_tail_gesture", gesture, 0);
    mark();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h5E);
    idle(20);
    chk("t6_gesture", gesture, 8'h04);
    chk("t6_gv_cnt", gv_cnt - gv0, 1);
    chk("t6_link", link_up, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
